mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter_pkg.sv | 12 +
 rtl/mem_port_arbiter_arb_prio_sel.sv | 13 +
 rtl/mem_port_arbiter.sv | 108 ++++++++++
 tb/tb_mem_port_arbiter.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - shared FSM encoding and defaults for the memory port arbiter
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY_IF = 2'd1,
    BUSY_DS = 2'd2
  } state_e;

  localparam int STARVE_MAX_DEFAULT = 4;

endpackage

// File: rtl/mem_port_arbiter_arb_prio_sel.sv
// rtl/mem_port_arbiter_arb_prio_sel.sv - winner select: data side first unless fetch is starved
module arb_prio_sel (
  input  logic if_req,
  input  logic ds_req,
  input  logic starve_full,
  output logic sel_if,
  output logic sel_ds
);

  assign sel_if = if_req && (starve_full || !ds_req);
  assign sel_ds = ds_req && !(starve_full && if_req);

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one memory port between fetch and data-side requesters
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT,
  parameter int ADDR_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [31:0]       if_rdata,
  input  logic              ds_req,
  input  logic              ds_we,
  input  logic [ADDR_W-1:0] ds_addr,
  input  logic [31:0]       ds_wdata,
  input  logic [3:0]        ds_wstrb,
  output logic              ds_gnt,
  output logic              ds_rvalid,
  output logic [31:0]       ds_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wstrb,
  input  logic              mem_rvalid,
  input  logic [31:0]       mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] starve_cnt_q, starve_cnt_d;
  logic             starve_full;
  logic             sel_if, sel_ds;
  logic             resp, arb_en;

  assign starve_full = (starve_cnt_q == CNT_W'(STARVE_MAX));

  arb_prio_sel u_arb_prio_sel (
    .if_req      (if_req),
    .ds_req      (ds_req),
    .starve_full (starve_full),
    .sel_if      (sel_if),
    .sel_ds      (sel_ds)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Everything is gated by rst_n so outputs read zero while reset is held.
  always_comb begin
    state_d      = state_q;
    starve_cnt_d = starve_cnt_q;
    resp         = 1'b0;
    arb_en       = 1'b0;
    if_gnt       = 1'b0;
    if_rvalid    = 1'b0;
    if_rdata     = '0;
    ds_gnt       = 1'b0;
    ds_rvalid    = 1'b0;
    ds_rdata     = '0;
    mem_req      = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    mem_wstrb    = '0;
    if (rst_n) begin
      resp      = (state_q != IDLE) && mem_rvalid;
      if_rvalid = resp && (state_q == BUSY_IF);
      ds_rvalid = resp && (state_q == BUSY_DS);
      if (if_rvalid) if_rdata = mem_rdata;
      if (ds_rvalid) ds_rdata = mem_rdata;
      arb_en = (state_q == IDLE) || resp;
      if (resp) state_d = IDLE;
      if (arb_en && sel_ds) begin
        ds_gnt    = 1'b1;
        mem_req   = 1'b1;
        mem_we    = ds_we;
        mem_addr  = ds_addr;
        mem_wdata = ds_wdata;
        mem_wstrb = ds_wstrb;
        state_d   = BUSY_DS;
        if (!if_req) begin
          starve_cnt_d = '0;
        end else if (!starve_full) begin
          starve_cnt_d = starve_cnt_q + CNT_W'(1);
        end
      end else if (arb_en && sel_if) begin
        if_gnt       = 1'b1;
        mem_req      = 1'b1;
        mem_addr     = if_addr;
        state_d      = BUSY_IF;
        starve_cnt_d = '0;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - randomized and directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

  localparam int SM = 4;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [31:0]   if_rdata;
  logic          ds_req, ds_we;
  logic [AW-1:0] ds_addr;
  logic [31:0]   ds_wdata;
  logic [3:0]    ds_wstrb;
  logic          ds_gnt, ds_rvalid;
  logic [31:0]   ds_rdata;
  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wstrb;
  logic          mem_rvalid;
  logic [31:0]   mem_rdata;

  mem_port_arbiter #(.STARVE_MAX(SM), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ds_req(ds_req), .ds_we(ds_we), .ds_addr(ds_addr), .ds_wdata(ds_wdata), .ds_wstrb(ds_wstrb),
    .ds_gnt(ds_gnt), .ds_rvalid(ds_rvalid), .ds_rdata(ds_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wstrb(mem_wstrb), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: who owns the port (0 none, 1 fetch, 2 data) and how many data grants fetch has waited through.
  int owner  = 0;
  int starve = 0;
  int winner = 0;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_val({tag, "_ctl"}, {56'd0, if_gnt, if_rvalid, ds_gnt, ds_rvalid, mem_req, mem_we, 2'b00}, 64'd0);
    check_val({tag, "_rdata"}, {if_rdata, ds_rdata}, 64'd0);
    check_val({tag, "_cmd"}, {mem_addr, mem_wdata}, 64'd0);
    check_val({tag, "_strb"}, {60'd0, mem_wstrb}, 64'd0);
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic step();
    bit          resp, e_ifv, e_dsv, e_req, e_we;
    logic [31:0] e_if_rd, e_ds_rd, e_wd;
    logic [AW-1:0] e_addr;
    logic [3:0]  e_ws;
    int          w, owner_n;
    #2;
    resp    = (owner != 0) && mem_rvalid;
    e_ifv   = resp && (owner == 1);
    e_dsv   = resp && (owner == 2);
    e_if_rd = e_ifv ? mem_rdata : 32'd0;
    e_ds_rd = e_dsv ? mem_rdata : 32'd0;
    w = 0;
    if (owner == 0 || resp) begin
      if (ds_req) w = 2;
      if (if_req && (starve == SM || !ds_req)) w = 1;
    end
    e_req = (w != 0);
    e_we = 0; e_addr = '0; e_wd = '0; e_ws = '0;
    if (w == 1) e_addr = if_addr;
    if (w == 2) begin
      e_we = ds_we; e_addr = ds_addr; e_wd = ds_wdata; e_ws = ds_wstrb;
    end
    check_val("if_gnt", {63'd0, if_gnt}, {63'd0, w == 1});
    check_val("ds_gnt", {63'd0, ds_gnt}, {63'd0, w == 2});
    check_val("mem_req", {63'd0, mem_req}, {63'd0, e_req});
    check_val("mem_we", {63'd0, mem_we}, {63'd0, e_we});
    check_val("mem_addr", {32'd0, mem_addr}, {32'd0, e_addr});
    check_val("mem_wdata", {32'd0, mem_wdata}, {32'd0, e_wd});
    check_val("mem_wstrb", {60'd0, mem_wstrb}, {60'd0, e_ws});
    check_val("if_rvalid", {63'd0, if_rvalid}, {63'd0, e_ifv});
    check_val("ds_rvalid", {63'd0, ds_rvalid}, {63'd0, e_dsv});
    check_val("rdata", {if_rdata, ds_rdata}, {e_if_rd, e_ds_rd});
    if (w == 1) starve = 0;
    else if (w == 2) starve = if_req ? ((starve < SM) ? starve + 1 : SM) : 0;
    owner_n = (w != 0) ? w : (resp ? 0 : owner);
    winner  = w;
    @(posedge clk);
    owner = owner_n;
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; ds_req = 0; ds_we = 0; ds_addr = '0;
    ds_wdata = '0; ds_wstrb = '0; mem_rvalid = 0; mem_rdata = '0;
  endtask

  int exp_seq [6] = '{2, 2, 2, 2, 1, 2};
  bit if_act, ds_act;
  int cyc, resp_at;

  initial begin
    // Reset with every input asserted: outputs must all read zero.
    rst_n = 0;
    if_req = 1; if_addr = 32'h44; ds_req = 1; ds_we = 1; ds_addr = 32'h88;
    ds_wdata = 32'hA5A5A5A5; ds_wstrb = 4'hF; mem_rvalid = 1; mem_rdata = 32'hFFFF0000;
    #3 check_zero("reset");
    @(negedge clk);
    idle_inputs();
    rst_n = 1;
    owner = 0; starve = 0;

    // Fetch only, 2-cycle memory latency.
    if_req = 1; if_addr = 32'h100;
    step();
    if_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'hDEADBEEF;
    step();
    mem_rvalid = 0;

    // Collision: data store first, fetch granted back-to-back on the store response.
    if_req = 1; if_addr = 32'h104;
    ds_req = 1; ds_we = 1; ds_addr = 32'h200; ds_wdata = 32'h12345678; ds_wstrb = 4'hF;
    step();
    check_val("coll_first", winner, 2);
    ds_req = 0;
    mem_rvalid = 1; mem_rdata = 32'h0;
    step();
    check_val("coll_b2b", winner, 1);
    if_req = 0; mem_rdata = 32'h00C0FFEE;
    step();
    mem_rvalid = 0;

    // Starvation with 1-cycle memory.
    if_req = 1; if_addr = 32'h300;
    ds_req = 1; ds_we = 0; ds_addr = 32'h400; ds_wstrb = 4'h0; ds_wdata = '0;
    for (int i = 0; i < 6; i++) begin
      mem_rvalid = (i != 0); mem_rdata = 32'h1000 + i;
      step();
      check_val("starve_seq", winner, exp_seq[i]);
    end
    if_req = 0; ds_req = 0; mem_rvalid = 1; mem_rdata = 32'h2222;
    step();
    mem_rvalid = 0;

    // Reset while a data transaction is outstanding.
    ds_req = 1; ds_we = 1; ds_addr = 32'h500; ds_wdata = 32'h55; ds_wstrb = 4'h3;
    step();
    rst_n = 0; mem_rvalid = 1; mem_rdata = 32'hBAD0BAD0; if_req = 1; if_addr = 32'h600;
    #1 check_zero("rst_mid");
    @(negedge clk);
    rst_n = 1; owner = 0; starve = 0;
    if_req = 0; ds_req = 0;
    step();
    mem_rvalid = 0; if_req = 1; if_addr = 32'h600;
    step();
    check_val("post_rst_if", winner, 1);
    if_req = 0; mem_rvalid = 1; mem_rdata = 32'h600600;
    step();
    mem_rvalid = 0;

    // Withdrawn data request during a fetch, then a stray response in IDLE.
    if_req = 1; if_addr = 32'h700;
    step();
    if_req = 0; ds_req = 1; ds_we = 0; ds_addr = 32'h800;
    step();
    ds_req = 0;
    step();
    mem_rvalid = 1; mem_rdata = 32'h77;
    step();
    mem_rdata = 32'h99;
    step();
    check_val("stray_idle", winner, 0);
    mem_rvalid = 0;

    // Randomized traffic against the model.
    idle_inputs();
    if_act = 0; ds_act = 0; cyc = 0; resp_at = 0;
    for (int n = 0; n < 3000; n++) begin
      if (!if_act && $urandom_range(0, 2) == 0) begin
        if_act = 1; if_addr = $urandom;
      end else if (if_act && $urandom_range(0, 15) == 0) begin
        if_act = 0;
      end
      if (!ds_act && $urandom_range(0, 1) == 0) begin
        ds_act = 1; ds_we = $urandom_range(0, 1); ds_addr = $urandom;
        ds_wdata = $urandom; ds_wstrb = 4'($urandom);
      end else if (ds_act && $urandom_range(0, 15) == 0) begin
        ds_act = 0;
      end
      if_req = if_act; ds_req = ds_act;
      mem_rdata  = $urandom;
      mem_rvalid = (owner != 0) ? (cyc == resp_at) : ($urandom_range(0, 7) == 0);
      step();
      if (winner == 1) if_act = 0;
      if (winner == 2) ds_act = 0;
      if (winner != 0) resp_at = cyc + 1 + int'($urandom_range(0, 2));
      cyc++;
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
